// File: rtl/router_pkg.sv
// router_pkg: shared types and constants for the mesh router.
//   FLIT_t          packed flit: valid, type, head destination, payload
//   FLIT_TYPE_t     HEAD / BODY / TAIL
//   GLOBAL_STATE_t  input-unit state code (IDLE, ROUTING, WAITING, ACTIVE)
//   PORT_STATUS_t   PORT_FREE / PORT_OCCUPIED
//   Port indices    LOCAL=0, NORTH=1, EAST=2, SOUTH=3, WEST=4
//   xy_route()      dimension-ordered (X first, then Y) route selection
package router_pkg;

    localparam int NUM_OF_PORTS = 5;
    localparam int PORT_W       = 3;
    localparam int COORD_W      = 4;
    localparam int PAYLOAD_W    = 16;

    localparam logic [PORT_W-1:0] LOCAL = 3'd0;
    localparam logic [PORT_W-1:0] NORTH = 3'd1;
    localparam logic [PORT_W-1:0] EAST  = 3'd2;
    localparam logic [PORT_W-1:0] SOUTH = 3'd3;
    localparam logic [PORT_W-1:0] WEST  = 3'd4;

    typedef enum logic [1:0] {
        HEAD = 2'd0,
        BODY = 2'd1,
        TAIL = 2'd2
    } FLIT_TYPE_t;

    // State codes kept as plain constants so legacy tools can read them.
    typedef logic [1:0] GLOBAL_STATE_t;
    localparam GLOBAL_STATE_t IDLE    = 2'd0;
    localparam GLOBAL_STATE_t ROUTING = 2'd1;
    localparam GLOBAL_STATE_t WAITING = 2'd2;
    localparam GLOBAL_STATE_t ACTIVE  = 2'd3;

    typedef enum logic {
        PORT_FREE     = 1'b0,
        PORT_OCCUPIED = 1'b1
    } PORT_STATUS_t;

    typedef struct packed {
        logic                 valid;
        FLIT_TYPE_t           flit_type;
        logic [COORD_W-1:0]   dest_x;
        logic [COORD_W-1:0]   dest_y;
        logic [PAYLOAD_W-1:0] payload;
    } FLIT_t;

    // X is resolved completely before Y, which keeps XY routing deadlock-free.
    function automatic logic [PORT_W-1:0] xy_route(
        input logic [COORD_W-1:0] dest_x,
        input logic [COORD_W-1:0] dest_y,
        input logic [COORD_W-1:0] here_x,
        input logic [COORD_W-1:0] here_y
    );
        if (dest_x > here_x)      return EAST;
        else if (dest_x < here_x) return WEST;
        else if (dest_y > here_y) return NORTH;
        else if (dest_y < here_y) return SOUTH;
        return LOCAL;
    endfunction

endpackage

// File: rtl/flit_fifo.sv
// flit_fifo: synchronous FIFO of FLIT_t with show-ahead read.
//   clk, reset  clock and synchronous active-high reset
//   push, wr_data   write request and data (ignored when full without a pop)
//   pop             read request (ignored when empty)
//   rd_data         current head entry, valid whenever empty is low
//   full, empty, count  occupancy status
// DEPTH may be any value >= 1; pointers wrap explicitly at DEPTH-1.
module flit_fifo
    import router_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  FLIT_t                      wr_data,
    input  logic                       pop,
    output FLIT_t                      rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    FLIT_t            mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_push;
    logic             do_pop;

    assign full  = (count_reg == CNT_W'(DEPTH));
    assign empty = (count_reg == '0);
    assign count = count_reg;

    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Show-ahead: the head entry is visible without a read request.
    assign rd_data = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= (wr_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= (rd_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/input_unit_fsm.sv
// input_unit_fsm: receive side of a router input port.
//   clk, reset        clock and synchronous active-high reset
//   i_upstream_req    channel request from the upstream output unit
//   o_upstream_ack    one-cycle channel grant (combinational)
//   i_flit            incoming flit, qualified by its valid bit
//   o_switch_req      one-hot request to the output unit chosen by XY routing
//   i_switch_ack      grant pulses from the output units
//   o_flit            flit toward the switch, '0 when none
//   o_gstate          current state
//   o_port_status     PORT_FREE in IDLE, PORT_OCCUPIED otherwise
//   o_fifo_count      buffer occupancy
//   o_error           sticky: overflow, flit in IDLE, or non-HEAD in ROUTING
module input_unit_fsm
    import router_pkg::*;
#(
    parameter int BUF_DEPTH = 8,
    parameter int ROUTER_X  = 0,
    parameter int ROUTER_Y  = 0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           i_upstream_req,
    output logic                           o_upstream_ack,
    input  FLIT_t                          i_flit,
    output logic [NUM_OF_PORTS-1:0]        o_switch_req,
    input  logic [NUM_OF_PORTS-1:0]        i_switch_ack,
    output FLIT_t                          o_flit,
    output GLOBAL_STATE_t                  o_gstate,
    output PORT_STATUS_t                   o_port_status,
    output logic [$clog2(BUF_DEPTH+1)-1:0] o_fifo_count,
    output logic                           o_error
);

    localparam logic [COORD_W-1:0] HERE_X = COORD_W'(ROUTER_X);
    localparam logic [COORD_W-1:0] HERE_Y = COORD_W'(ROUTER_Y);

    GLOBAL_STATE_t     state_reg, state_next;
    logic [PORT_W-1:0] route_reg, route_next;
    logic              error_reg;

    FLIT_t fifo_head;
    logic  fifo_full;
    logic  fifo_empty;
    logic  push;
    logic  pop;
    logic  proto_err;
    logic  overflow;
    logic  switch_granted;

    flit_fifo #(
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .wr_data (i_flit),
        .pop     (pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (o_fifo_count)
    );

    generate
        for (genvar gi = 0; gi < NUM_OF_PORTS; gi++) begin : g_port
            assign o_switch_req[gi] = (state_reg == WAITING) && (route_reg == PORT_W'(gi));
        end
    endgenerate

    // Only the grant from the requested output unit counts.
    assign switch_granted = |(i_switch_ack & o_switch_req);

    // pop is only raised when non-empty, so a full FIFO with pop never overflows.
    assign overflow = push && fifo_full && !pop;

    always_comb begin
        state_next     = state_reg;
        route_next     = route_reg;
        o_upstream_ack = 1'b0;
        push           = 1'b0;
        pop            = 1'b0;
        proto_err      = 1'b0;
        o_flit         = '0;
        case (state_reg)
            IDLE: begin
                // Leftover flits block a new grant until the port is reset.
                if (i_upstream_req && fifo_empty) begin
                    o_upstream_ack = 1'b1;
                    state_next     = ROUTING;
                end
                if (i_flit.valid) begin
                    proto_err = 1'b1;
                end
            end
            ROUTING: begin
                if (i_flit.valid) begin
                    if (i_flit.flit_type == HEAD) begin
                        push       = 1'b1;
                        route_next = xy_route(i_flit.dest_x, i_flit.dest_y, HERE_X, HERE_Y);
                        state_next = WAITING;
                    end else begin
                        proto_err = 1'b1;
                    end
                end
            end
            WAITING: begin
                push = i_flit.valid;
                if (switch_granted) begin
                    state_next = ACTIVE;
                end
            end
            ACTIVE: begin
                push = i_flit.valid;
                if (!fifo_empty) begin
                    pop    = 1'b1;
                    o_flit = fifo_head;
                    if (fifo_head.flit_type == TAIL) begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            route_reg <= LOCAL;
            error_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            route_reg <= route_next;
            error_reg <= error_reg | proto_err | overflow;
        end
    end

    assign o_gstate      = state_reg;
    assign o_port_status = (state_reg == IDLE) ? PORT_FREE : PORT_OCCUPIED;
    assign o_error       = error_reg;

endmodule

// File: tb/tb_input_unit_fsm.sv
// tb_input_unit_fsm: directed bench for input_unit_fsm.
// dut8: router (1,1), 8-entry buffer. dut4: router (1,1), 4-entry buffer.
`timescale 1ns/1ps
module tb_input_unit_fsm;
    import router_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst8, req8, ack8, err8;
    FLIT_t         flit8, oflit8;
    logic [4:0]    swack8, swreq8;
    GLOBAL_STATE_t gst8;
    PORT_STATUS_t  pst8;
    logic [3:0]    cnt8;

    logic          rst4, req4, ack4, err4;
    FLIT_t         flit4, oflit4;
    logic [4:0]    swack4, swreq4;
    GLOBAL_STATE_t gst4;
    PORT_STATUS_t  pst4;
    logic [2:0]    cnt4;

    input_unit_fsm #(.BUF_DEPTH(8), .ROUTER_X(1), .ROUTER_Y(1)) dut8 (
        .clk(clk), .reset(rst8), .i_upstream_req(req8), .o_upstream_ack(ack8),
        .i_flit(flit8), .o_switch_req(swreq8), .i_switch_ack(swack8), .o_flit(oflit8),
        .o_gstate(gst8), .o_port_status(pst8), .o_fifo_count(cnt8), .o_error(err8)
    );

    input_unit_fsm #(.BUF_DEPTH(4), .ROUTER_X(1), .ROUTER_Y(1)) dut4 (
        .clk(clk), .reset(rst4), .i_upstream_req(req4), .o_upstream_ack(ack4),
        .i_flit(flit4), .o_switch_req(swreq4), .i_switch_ack(swack4), .o_flit(oflit4),
        .o_gstate(gst4), .o_port_status(pst4), .o_fifo_count(cnt4), .o_error(err4)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    function automatic FLIT_t mk(input FLIT_TYPE_t t, input int dx, input int dy, input int pl);
        FLIT_t f;
        f.valid     = 1'b1;
        f.flit_type = t;
        f.dest_x    = 4'(dx);
        f.dest_y    = 4'(dy);
        f.payload   = 16'(pl);
        return f;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Two-flit packet through dut8; checks the switch request and head output.
    task automatic route_case(input int dx, input int dy, input logic [4:0] exp, input string tag);
        FLIT_t h, t;
        h = mk(HEAD, dx, dy, 16'h100 + dx);
        t = mk(TAIL, dx, dy, 16'h200 + dy);
        req8 = 1'b1; tick();
        req8 = 1'b0; flit8 = h; tick();
        flit8 = t; swack8 = exp; #1;
        check({tag, "_switch_req"}, 32'(swreq8), 32'(exp));
        tick();
        flit8 = '0; swack8 = '0; #1;
        check({tag, "_head_out"}, 32'(oflit8), 32'(h));
        tick(); tick(); #1;
        check({tag, "_back_idle"}, 32'(gst8), 32'(IDLE));
    endtask

    FLIT_t p [5];
    FLIT_t h1, b1, t1, extra;
    FLIT_t q [6];

    initial begin
        rst8 = 1'b1; req8 = 1'b0; flit8 = '0; swack8 = '0;
        rst4 = 1'b1; req4 = 1'b0; flit4 = '0; swack4 = '0;
        tick(); tick();
        rst8 = 1'b0; rst4 = 1'b0; #1;

        // Reset state
        check("rst_state",  32'(gst8),   32'(IDLE));
        check("rst_count",  32'(cnt8),   32'd0);
        check("rst_error",  32'(err8),   32'd0);
        check("rst_status", 32'(pst8),   32'(PORT_FREE));
        check("rst_ack",    32'(ack8),   32'd0);
        check("rst_swreq",  32'(swreq8), 32'd0);
        check("rst_flit",   32'(oflit8), 32'd0);

        // Basic 3-flit packet to (3,1): EAST
        h1 = mk(HEAD, 3, 1, 16'hC001);
        b1 = mk(BODY, 3, 1, 16'hC002);
        t1 = mk(TAIL, 3, 1, 16'hC003);
        req8 = 1'b1; #1;
        check("ack_at_t", 32'(ack8), 32'd1);
        tick();
        req8 = 1'b0; flit8 = h1; #1;
        check("ack_gone_t1", 32'(ack8), 32'd0);
        check("state_routing", 32'(gst8), 32'(ROUTING));
        check("status_occupied", 32'(pst8), 32'(PORT_OCCUPIED));
        tick();
        flit8 = b1; swack8 = 5'b11011; #1;
        check("state_waiting", 32'(gst8), 32'(WAITING));
        check("east_swreq", 32'(swreq8), 32'h04);
        tick();
        flit8 = t1; swack8 = 5'b00100; #1;
        check("other_acks_ignored", 32'(gst8), 32'(WAITING));
        check("count_two", 32'(cnt8), 32'd2);
        tick();
        flit8 = '0; swack8 = '0; #1;
        check("state_active", 32'(gst8), 32'(ACTIVE));
        check("active_swreq_zero", 32'(swreq8), 32'd0);
        check("count_three", 32'(cnt8), 32'd3);
        check("out_head", 32'(oflit8), 32'(h1));
        tick(); #0;
        check("out_body", 32'(oflit8), 32'(b1));
        tick();
        check("out_tail", 32'(oflit8), 32'(t1));
        tick();
        check("idle_after_tail", 32'(gst8), 32'(IDLE));
        check("flit_zero_idle", 32'(oflit8), 32'd0);
        check("count_zero_end", 32'(cnt8), 32'd0);
        check("no_error_basic", 32'(err8), 32'd0);

        // Route selection
        route_case(1, 1, 5'b00001, "local");
        route_case(1, 0, 5'b01000, "south");
        route_case(0, 2, 5'b10000, "west");
        route_case(1, 3, 5'b00010, "north");

        // Delayed switch grant, 5 flits buffered
        p[0] = mk(HEAD, 1, 3, 16'hA0);
        p[1] = mk(BODY, 1, 3, 16'hA1);
        p[2] = mk(BODY, 1, 3, 16'hA2);
        p[3] = mk(BODY, 1, 3, 16'hA3);
        p[4] = mk(TAIL, 1, 3, 16'hA4);
        extra = mk(BODY, 0, 0, 16'hEE);
        req8 = 1'b1; tick();
        req8 = 1'b0; flit8 = p[0]; tick();
        for (int i = 1; i < 5; i++) begin
            flit8 = p[i]; tick();
        end
        flit8 = '0; tick(); tick();
        check("delay_peak_count", 32'(cnt8), 32'd5);
        check("delay_still_waiting", 32'(gst8), 32'(WAITING));
        check("delay_no_error", 32'(err8), 32'd0);
        swack8 = 5'b00010; tick();
        swack8 = '0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("delay_out_%0d", i), 32'(oflit8), 32'(p[i]));
            // A flit slipped in while the tail leaves stays behind in IDLE.
            if (i == 4) flit8 = extra;
            tick();
            flit8 = '0;
        end
        check("drain_idle", 32'(gst8), 32'(IDLE));
        check("leftover_count", 32'(cnt8), 32'd1);
        check("drain_no_error", 32'(err8), 32'd0);

        // Request held off while the FIFO is not empty
        req8 = 1'b1; #1;
        check("ack_held_0", 32'(ack8), 32'd0);
        tick();
        check("ack_held_1", 32'(ack8), 32'd0);
        check("held_state_idle", 32'(gst8), 32'(IDLE));
        req8 = 1'b0;
        rst8 = 1'b1; tick();
        rst8 = 1'b0;
        check("cleared_count", 32'(cnt8), 32'd0);
        req8 = 1'b1; #1;
        check("ack_after_empty", 32'(ack8), 32'd1);
        tick();

        // Reset mid-ACTIVE with 3 flits buffered
        req8 = 1'b0; flit8 = mk(HEAD, 2, 1, 16'hB0); tick();
        flit8 = mk(BODY, 2, 1, 16'hB1); tick();
        flit8 = mk(BODY, 2, 1, 16'hB2); swack8 = 5'b00100; tick();
        flit8 = '0; swack8 = '0;
        check("mid_active_state", 32'(gst8), 32'(ACTIVE));
        check("mid_active_count", 32'(cnt8), 32'd3);
        rst8 = 1'b1; tick();
        rst8 = 1'b0;
        check("mid_rst_state", 32'(gst8), 32'(IDLE));
        check("mid_rst_count", 32'(cnt8), 32'd0);
        check("mid_rst_ack", 32'(ack8), 32'd0);
        check("mid_rst_swreq", 32'(swreq8), 32'd0);
        check("mid_rst_flit", 32'(oflit8), 32'd0);
        check("mid_rst_error", 32'(err8), 32'd0);
        check("mid_rst_status", 32'(pst8), 32'(PORT_FREE));

        // Non-HEAD flit in ROUTING: error, stay in ROUTING
        req8 = 1'b1; tick();
        req8 = 1'b0; flit8 = mk(BODY, 2, 1, 16'hD1); tick();
        flit8 = '0;
        check("bad_head_state", 32'(gst8), 32'(ROUTING));
        check("bad_head_error", 32'(err8), 32'd1);

        // Overflow on a 4-entry buffer, grant withheld
        for (int i = 0; i < 6; i++) begin
            q[i] = mk((i == 0) ? HEAD : ((i == 5) ? TAIL : BODY), 3, 1, 16'hF0 + i);
        end
        req4 = 1'b1; tick();
        req4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            flit4 = q[i]; tick();
        end
        flit4 = q[4]; #1;
        check("ovf_full_count", 32'(cnt4), 32'd4);
        check("ovf_no_error_yet", 32'(err4), 32'd0);
        tick();
        flit4 = q[5];
        check("ovf_error_set", 32'(err4), 32'd1);
        check("ovf_count_held", 32'(cnt4), 32'd4);
        tick();
        flit4 = '0;
        repeat (3) tick();
        check("ovf_error_sticky", 32'(err4), 32'd1);
        check("ovf_count_final", 32'(cnt4), 32'd4);
        check("ovf_state_waiting", 32'(gst4), 32'(WAITING));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
